// File: rtl/pong_uart_pkg.sv
// Shared constants for the pong UART key link: key codes, UART FSM states, default line rate.
// The game-side decoder imports the same package so both ends agree on the byte values.
package pong_uart_pkg;

    localparam logic [7:0] KEY_UP1 = 8'h77;
    localparam logic [7:0] KEY_DN1 = 8'h73;
    localparam logic [7:0] KEY_UP2 = 8'h70;
    localparam logic [7:0] KEY_DN2 = 8'h6C;

    localparam int unsigned DEFAULT_BAUD = 9600;
    localparam int unsigned N_KEYS       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Button index to key byte: [0] up1, [1] down1, [2] up2, [3] down2.
    function automatic logic [7:0] key_code(input logic [1:0] idx);
        logic [7:0] code;
        case (idx)
            2'd0:    code = KEY_UP1;
            2'd1:    code = KEY_DN1;
            2'd2:    code = KEY_UP2;
            default: code = KEY_DN2;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_tx_fifo.sv
// Small synchronous byte queue between the key arbiter and the UART transmitter.
// Push while full is taken only when a pop happens on the same edge; full/empty are registered.
module key_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            full    <= (w_count_nxt == CNT_W'(DEPTH));
            empty   <= (w_count_nxt == CNT_W'(0));
        end
    end

endmodule

// File: rtl/pong_key_tx.sv
// Controller end of the pong key link: turns button presses and holds into key bytes
// and sends them as UART 8N1 frames on tx.
module pong_key_tx
    import pong_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned BAUD          = DEFAULT_BAUD,
    parameter int unsigned REPEAT_CYCLES = 5_000_000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       dropped
);

    localparam int unsigned DIV       = CLK_HZ / BAUD;
    localparam int unsigned BIT_CNT_W = $clog2(DIV);
    localparam int unsigned RPT_W     = $clog2(REPEAT_CYCLES);

    logic [N_KEYS-1:0] r_btn_prev;
    logic [N_KEYS-1:0] r_pend;
    logic [RPT_W-1:0]  r_rpt_cnt [N_KEYS];
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_wrap;
    logic [N_KEYS-1:0] w_grant;
    logic [1:0]        w_win_idx;
    logic              w_req;
    logic [7:0]        w_code;
    logic              w_pop;
    logic              w_drop;
    logic [7:0]        w_fifo_dout;
    logic              w_fifo_empty;

    uart_state_e          r_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shreg;
    logic                 w_bit_end;

    // Press and hold-repeat detection per button.
    always_comb begin
        for (int i = 0; i < int'(N_KEYS); i++) begin
            w_press[i] = btn[i] && !r_btn_prev[i];
            w_wrap[i]  = btn[i] && r_btn_prev[i] &&
                         (r_rpt_cnt[i] == RPT_W'(REPEAT_CYCLES - 1));
        end
    end

    // Lowest pending index wins the single enqueue slot of this cycle.
    always_comb begin
        w_win_idx = 2'd0;
        for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_win_idx = 2'(i);
            end
        end
    end

    assign w_req   = |r_pend;
    assign w_grant = w_req ? (4'b0001 << w_win_idx) : 4'b0000;
    assign w_code  = key_code(w_win_idx);
    assign w_pop   = (r_state == IDLE) && !w_fifo_empty;
    assign w_drop  = w_req && fifo_full && !w_pop;

    // The granted pend bit clears whether or not the queue accepts it; a new event re-arms it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_btn_prev <= '0;
            r_pend     <= '0;
            for (int i = 0; i < int'(N_KEYS); i++) begin
                r_rpt_cnt[i] <= '0;
            end
        end else begin
            r_btn_prev <= btn;
            r_pend     <= (r_pend & ~w_grant) | w_press | w_wrap;
            for (int i = 0; i < int'(N_KEYS); i++) begin
                if (!btn[i] || w_press[i] || w_wrap[i]) begin
                    r_rpt_cnt[i] <= '0;
                end else begin
                    r_rpt_cnt[i] <= r_rpt_cnt[i] + RPT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dropped <= 1'b0;
        end else begin
            dropped <= w_drop;
        end
    end

    key_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_req),
        .pop   (w_pop),
        .din   (w_code),
        .dout  (w_fifo_dout),
        .full  (fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_bit_end = (r_bit_cnt == BIT_CNT_W'(DIV - 1));

    // Transmit FSM; tx is registered with the value for the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    tx <= 1'b1;
                    if (w_pop) begin
                        r_shreg   <= w_fifo_dout;
                        r_bit_cnt <= '0;
                        r_state   <= START;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        tx        <= r_shreg[0];
                        r_state   <= DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            tx      <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            tx        <= r_shreg[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        tx        <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_key_tx.sv
// Bench for pong_key_tx at DIV=10, REPEAT_CYCLES=200: a UART frame monitor plus
// table-driven button vectors and hand-written reset / full-queue sequences.
module tb_pong_key_tx;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       dropped;

    pong_key_tx #(
        .CLK_HZ        (1_000_000),
        .BAUD          (100_000),
        .REPEAT_CYCLES (200),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int busy_cnt = 0;
    int drop_cnt = 0;
    int full_cnt = 0;
    always @(negedge clk) begin
        if (busy === 1'b1)      busy_cnt++;
        if (dropped === 1'b1)   drop_cnt++;
        if (fifo_full === 1'b1) full_cnt++;
    end

    // Frame monitor: samples mid-bit, records byte, start cycle and stop level; reset aborts.
    logic [7:0] rx_q [$];
    int         rx_t_q [$];
    logic       rx_stop_q [$];
    int         mon_start;
    logic       mon_abort;
    logic [7:0] mon_byte;
    logic       mon_stop;

    always begin
        @(negedge clk);
        if (reset === 1'b1 && tx === 1'b0) begin
            mon_start = cyc;
            mon_abort = 1'b0;
            mon_byte  = 8'h00;
            mon_stop  = 1'b0;
            for (int n = 1; n <= 95; n++) begin
                @(negedge clk);
                if (reset !== 1'b1) begin
                    mon_abort = 1'b1;
                    break;
                end
                if (n >= 15 && n <= 85 && ((n - 5) % 10) == 0) mon_byte[(n - 15) / 10] = tx;
                if (n == 95) mon_stop = tx;
            end
            if (!mon_abort) begin
                rx_q.push_back(mon_byte);
                rx_t_q.push_back(mon_start);
                rx_stop_q.push_back(mon_stop);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] name;
        logic [3:0]  btn;
        int          hold;
        int          total;
        int          n_exp;
        int          busy_exp;
        logic [31:0] exp_b;   // byte k at [8k+7:8k]
        int          t_first;
        int          t_step;
    } vec_t;

    function automatic vec_t mkv(input logic [63:0] nm, input logic [3:0] b, input int hold,
                                 input int total, input int n, input int busy_n,
                                 input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] e3,
                                 input int tf, input int ts);
        vec_t v;
        v.name = nm; v.btn = b; v.hold = hold; v.total = total; v.n_exp = n;
        v.busy_exp = busy_n; v.exp_b = {e3, e2, e1, e0}; v.t_first = tf; v.t_step = ts;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int d, base, b0, dr0, got;
        string nm;
        nm   = $sformatf("%s", v.name);
        base = rx_q.size();
        b0   = busy_cnt;
        dr0  = drop_cnt;
        d    = cyc;
        btn  = v.btn;
        repeat (v.hold) @(negedge clk);
        btn = 4'b0000;
        repeat (v.total - v.hold) @(negedge clk);
        got = rx_q.size() - base;
        check({nm, " frames"}, got, v.n_exp);
        for (int k = 0; k < v.n_exp && k < got; k++) begin
            check($sformatf("%s byte%0d", nm, k), int'(rx_q[base + k]), int'(v.exp_b[k*8 +: 8]));
            check($sformatf("%s start%0d", nm, k), rx_t_q[base + k] - d, v.t_first + k * v.t_step);
            check($sformatf("%s stop%0d", nm, k), int'(rx_stop_q[base + k]), 1);
        end
        check({nm, " busy_cycles"}, busy_cnt - b0, v.busy_exp);
        check({nm, " dropped"}, drop_cnt - dr0, 0);
    endtask

    vec_t       vecs [6];
    logic [7:0] exp4 [5];
    logic [7:0] exp6 [6];
    int         a, base, dr0, f0, got, nf, nd;

    initial begin
        reset = 1'b0;
        btn   = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset tx", int'(tx), 1);
        check("reset busy", int'(busy), 0);
        check("reset fifo_full", int'(fifo_full), 0);
        check("reset dropped", int'(dropped), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        vecs[0] = mkv(64'("up1"),      4'b0001,   5, 130, 1, 100, 8'h77, 8'h00, 8'h00, 8'h00, 3,   0);
        vecs[1] = mkv(64'("dn1_dn2"),  4'b1010,   5, 240, 2, 200, 8'h73, 8'h6C, 8'h00, 8'h00, 3, 101);
        vecs[2] = mkv(64'("hold_up2"), 4'b0100, 650, 900, 4, 400, 8'h70, 8'h70, 8'h70, 8'h70, 3, 200);
        vecs[3] = mkv(64'("dn2"),      4'b1000,   1, 130, 1, 100, 8'h6C, 8'h00, 8'h00, 8'h00, 3,   0);
        vecs[4] = mkv(64'("up1_dn1"),  4'b0011,   3, 240, 2, 200, 8'h77, 8'h73, 8'h00, 8'h00, 3, 101);
        vecs[5] = mkv(64'("all4"),     4'b1111,   2, 450, 4, 400, 8'h77, 8'h73, 8'h70, 8'h6C, 3, 101);
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Exact edge positions of one 0x77 frame.
        for (int n = 0; n < 130; n++) begin
            if (n == 0) btn = 4'b0001;
            if (n == 5) btn = 4'b0000;
            @(negedge clk);
            case (n + 1)
                2:   begin check("lat tx+2", int'(tx), 1); check("lat busy+2", int'(busy), 0); end
                3:   begin check("lat tx+3", int'(tx), 0); check("lat busy+3", int'(busy), 1); end
                92:  check("lat tx+92", int'(tx), 0);
                93:  check("lat tx+93", int'(tx), 1);
                102: check("lat busy+102", int'(busy), 1);
                103: check("lat busy+103", int'(busy), 0);
                default: ;
            endcase
        end

        // Six events inside one frame: queue fills, one byte dropped.
        exp4 = '{8'h77, 8'h73, 8'h70, 8'h6C, 8'h77};
        base = rx_q.size(); dr0 = drop_cnt; f0 = full_cnt;
        for (int n = 0; n < 600; n++) begin
            case (n)
                0:  btn = 4'b1111;
                3:  btn = 4'b0000;
                6:  btn = 4'b0011;
                10: btn = 4'b0000;
                default: ;
            endcase
            @(negedge clk);
        end
        got = rx_q.size() - base;
        check("burst frames", got, 5);
        for (int k = 0; k < 5 && k < got; k++)
            check($sformatf("burst byte%0d", k), int'(rx_q[base + k]), int'(exp4[k]));
        check("burst dropped pulses", drop_cnt - dr0, 1);
        check("burst full seen", int'(full_cnt - f0 > 0), 1);

        // Push lands on the same edge the FSM pops from a full queue.
        exp6 = '{8'h77, 8'h73, 8'h70, 8'h6C, 8'h77, 8'h6C};
        base = rx_q.size(); dr0 = drop_cnt; nf = 0; nd = 0;
        for (int n = 0; n < 700; n++) begin
            case (n)
                0:   btn = 4'b1111;
                3:   btn = 4'b0000;
                6:   btn = 4'b0001;
                10:  btn = 4'b0000;
                102: btn = 4'b1000;
                106: btn = 4'b0000;
                default: ;
            endcase
            @(negedge clk);
            if (n + 1 >= 10 && n + 1 <= 110) begin
                if (fifo_full !== 1'b1) nf++;
                if (dropped !== 1'b0)   nd++;
            end
        end
        got = rx_q.size() - base;
        check("pushpop full low samples", nf, 0);
        check("pushpop dropped samples", nd, 0);
        check("pushpop total drops", drop_cnt - dr0, 0);
        check("pushpop frames", got, 6);
        for (int k = 0; k < 6 && k < got; k++)
            check($sformatf("pushpop byte%0d", k), int'(rx_q[base + k]), int'(exp6[k]));

        // Reset during data bit 3, then release with btn[0] still held.
        base = rx_q.size();
        a = cyc;
        for (int n = 0; n < 300; n++) begin
            case (n)
                0:  btn = 4'b0001;
                45: reset = 1'b0;
                48: reset = 1'b1;
                70: btn = 4'b0000;
                default: ;
            endcase
            @(negedge clk);
            if (n + 1 == 45) begin
                check("midframe tx bit3", int'(tx), 0);
                check("midframe busy", int'(busy), 1);
            end
            if (n + 1 == 46) begin
                check("abort tx", int'(tx), 1);
                check("abort busy", int'(busy), 0);
                check("abort fifo_full", int'(fifo_full), 0);
            end
        end
        got = rx_q.size() - base;
        check("after reset frames", got, 1);
        if (got >= 1) begin
            check("after reset byte", int'(rx_q[base]), 8'h77);
            check("after reset start", rx_t_q[base] - a, 51);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
